// File: rtl/instr_loader_pkg.sv
// Shared constants, instruction encodings and loader state type.
package instr_loader_pkg;

  localparam logic RESET = 1'b0;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOOP       = 32'h0000_0013;
  localparam logic [WORD_W-1:0] HALT_INSTR = 32'h0000_0063;

  typedef enum logic [2:0] {
    CLEAR,
    RECEIVE,
    DRAIN,
    HALT,
    DONE
  } loader_state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs little-endian stream bytes into 32-bit words; word/valid are combinational
// so the loader can register the memory write on the same edge the byte is taken.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_last,
  input  logic              i_flush,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word,
  output logic              o_partial
);

  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_word;
  logic [4:0]        w_shift;

  assign w_shift      = {r_idx, 3'b000};
  assign o_word       = r_word | (WORD_W'(i_byte) << w_shift);
  assign o_word_valid = i_push && ((r_idx == 2'd3) || i_last);
  assign o_partial    = o_word_valid && (r_idx != 2'd3);

  // Byte index and accumulated lower bytes; cleared whenever a word is emitted.
  always_ff @(posedge clk) begin
    if (rst == RESET || i_flush) begin
      r_idx  <= 2'd0;
      r_word <= '0;
    end else if (i_push) begin
      if (o_word_valid) begin
        r_idx  <= 2'd0;
        r_word <= '0;
      end else begin
        r_idx  <= r_idx + 2'd1;
        r_word <= o_word;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: clears imem to NOOP, loads a byte stream, writes a halt into the
// last word, then releases the core.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned INSTR_ADDRESS_WIDTH = 5,
  parameter int unsigned CPU_DATA_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [BYTE_W-1:0]              s_data,
  input  logic                           s_last,
  output logic                           imem_we,
  output logic [INSTR_ADDRESS_WIDTH-1:0] imem_addr,
  output logic [CPU_DATA_WIDTH-1:0]      imem_wdata,
  output logic                           cpu_rst,
  output logic                           done,
  output logic                           err_overflow,
  output logic                           err_misaligned
);

  localparam logic [INSTR_ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  loader_state_t                  r_state;
  logic [INSTR_ADDRESS_WIDTH-1:0] r_waddr;

  logic              w_accept;
  logic              w_at_cap;
  logic              w_push;
  logic              w_flush;
  logic              w_word_valid;
  logic              w_partial;
  logic [WORD_W-1:0] w_word;

  assign w_accept = s_valid && s_ready;
  assign w_at_cap = (r_waddr == LAST_ADDR);
  assign w_push   = w_accept && (r_state == RECEIVE) && !w_at_cap;
  assign w_flush  = (r_state != RECEIVE);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_byte       (s_data),
    .i_last       (s_last),
    .i_flush      (w_flush),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_partial    (w_partial)
  );

  // Loader FSM with registered memory port, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      r_state        <= CLEAR;
      r_waddr        <= '0;
      s_ready        <= 1'b0;
      imem_we        <= 1'b0;
      imem_addr      <= '0;
      imem_wdata     <= '0;
      cpu_rst        <= RESET;
      done           <= 1'b0;
      err_overflow   <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        CLEAR: begin
          // r_waddr doubles as the clear counter and wraps back to 0 for loading
          imem_we    <= 1'b1;
          imem_addr  <= r_waddr;
          imem_wdata <= CPU_DATA_WIDTH'(NOOP);
          r_waddr    <= r_waddr + INSTR_ADDRESS_WIDTH'(1);
          if (w_at_cap) r_state <= RECEIVE;
        end
        RECEIVE: begin
          s_ready <= 1'b1;
          if (w_accept) begin
            if (w_at_cap) begin
              err_overflow <= 1'b1;
              if (s_last) begin
                imem_we    <= 1'b1;
                imem_addr  <= LAST_ADDR;
                imem_wdata <= CPU_DATA_WIDTH'(HALT_INSTR);
                s_ready    <= 1'b0;
                r_state    <= DONE;
              end else begin
                r_state <= DRAIN;
              end
            end else if (w_word_valid) begin
              imem_we    <= 1'b1;
              imem_addr  <= r_waddr;
              imem_wdata <= CPU_DATA_WIDTH'(w_word);
              r_waddr    <= r_waddr + INSTR_ADDRESS_WIDTH'(1);
              if (w_partial) err_misaligned <= 1'b1;
              if (s_last) begin
                s_ready <= 1'b0;
                r_state <= HALT;
              end
            end
          end
        end
        DRAIN: begin
          if (w_accept && s_last) begin
            imem_we    <= 1'b1;
            imem_addr  <= LAST_ADDR;
            imem_wdata <= CPU_DATA_WIDTH'(HALT_INSTR);
            s_ready    <= 1'b0;
            r_state    <= DONE;
          end
        end
        HALT: begin
          imem_we    <= 1'b1;
          imem_addr  <= LAST_ADDR;
          imem_wdata <= CPU_DATA_WIDTH'(HALT_INSTR);
          r_state    <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          cpu_rst <= ~RESET;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized images against an image-level model.
`timescale 1ns/1ps
module tb_instr_loader;

  localparam int unsigned W     = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LAST  = DEPTH - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         s_last;
  logic         imem_we;
  logic [W-1:0] imem_addr;
  logic [31:0]  imem_wdata;
  logic         cpu_rst;
  logic         done;
  logic         err_overflow;
  logic         err_misaligned;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc_cnt = 0;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         wq[$];
  int unsigned accq[$];
  logic [7:0]  img[$];
  bit          rec_en = 1'b0;
  int unsigned last_acc_cyc;

  instr_loader #(.INSTR_ADDRESS_WIDTH(W), .CPU_DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .cpu_rst        (cpu_rst),
    .done           (done),
    .err_overflow   (err_overflow),
    .err_misaligned (err_misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Record memory writes of a load phase with the cycle they became visible.
  always @(negedge clk) begin
    wr_t t;
    if (rec_en && imem_we) begin
      t.addr = 32'(imem_addr);
      t.data = imem_wdata;
      t.cyc  = cyc_cnt;
      wq.push_back(t);
    end
  end

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err_overflow, err_misaligned} !== '0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b we=%b addr=%0d data=%h cpu_rst=%b done=%b ovf=%b mis=%b, expected all zero",
               s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err_overflow, err_misaligned);
    end
    rst = 1'b1;
  endtask

  task automatic test_clear();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b1 || 32'(imem_addr) != i || imem_wdata !== 32'h13 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear[%0d]: got we=%b addr=%0d data=%h ready=%b, expected we=1 addr=%0d data=00000013 ready=0",
                 i, imem_we, imem_addr, imem_wdata, s_ready, i);
      end
    end
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || s_ready !== 1'b1 || cpu_rst !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: got we=%b ready=%b cpu_rst=%b done=%b, expected we=0 ready=1 cpu_rst=0 done=0",
               imem_we, s_ready, cpu_rst, done);
    end
  endtask

  // Present img[0..n_drive-1]; s_last marks the final byte of the whole image.
  task automatic drive(input int unsigned n_drive, input bit gaps);
    int unsigned i = 0;
    int unsigned k = 0;
    int unsigned n = img.size();
    bit acc;
    while (i < n_drive && k < 4000) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = img[i];
      s_last  = (i == n - 1);
      acc     = s_valid && s_ready;
      if (acc) begin
        last_acc_cyc = cyc_cnt;
        if (((i % 4) == 3 || i == n - 1) && (i / 4) < LAST) accq.push_back(cyc_cnt);
      end
      @(negedge clk);
      k++;
      if (acc) i++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (i < n_drive) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d bytes, expected %0d", i, n_drive);
    end
  endtask

  task automatic run_and_check(input string name, input bit gaps);
    int unsigned n, nw, exp_cnt, k, done_cyc, exp_hcyc;
    bit ovf;
    logic [31:0] w;
    wq.delete();
    accq.delete();
    rec_en = 1'b1;
    drive(img.size(), gaps);
    k = 0;
    while (done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    done_cyc = cyc_cnt;
    rec_en = 1'b0;

    n       = img.size();
    nw      = (n + 3) / 4;
    ovf     = (nw > LAST);
    exp_cnt = ovf ? LAST : nw;

    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got done=%b, expected 1", name, done);
    end
    checks++;
    if (wq.size() != exp_cnt + 1) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, expected %0d", name, wq.size(), exp_cnt + 1);
    end
    for (int unsigned j = 0; j < exp_cnt && j < wq.size(); j++) begin
      w = '0;
      for (int unsigned b = 0; b < 4; b++)
        if (4 * j + b < n) w[8*b +: 8] = img[4*j + b];
      checks++;
      if (wq[j].addr != j || wq[j].data !== w) begin
        errors++;
        $display("FAIL %s_word[%0d]: got %h @%0d, expected %h @%0d", name, j, wq[j].data, wq[j].addr, w, j);
      end
      checks++;
      if (j >= accq.size() || wq[j].cyc != accq[j] + 1) begin
        errors++;
        $display("FAIL %s_latency[%0d]: got write cycle %0d, expected %0d", name, j, wq[j].cyc,
                 (j < accq.size()) ? accq[j] + 1 : 0);
      end
    end
    if (wq.size() > exp_cnt) begin
      exp_hcyc = ovf ? last_acc_cyc + 1 : wq[exp_cnt-1].cyc + 1;
      checks++;
      if (wq[exp_cnt].addr != LAST || wq[exp_cnt].data !== 32'h63 || wq[exp_cnt].cyc != exp_hcyc) begin
        errors++;
        $display("FAIL %s_halt: got %h @%0d cycle %0d, expected 00000063 @%0d cycle %0d", name,
                 wq[exp_cnt].data, wq[exp_cnt].addr, wq[exp_cnt].cyc, LAST, exp_hcyc);
      end
      checks++;
      if (done_cyc != wq[exp_cnt].cyc + 1) begin
        errors++;
        $display("FAIL %s_release_time: got done at cycle %0d, expected %0d", name, done_cyc, wq[exp_cnt].cyc + 1);
      end
    end
    checks++;
    if ({err_overflow, err_misaligned, cpu_rst, s_ready} !== {ovf, (!ovf && (n % 4) != 0), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s_status: got ovf=%b mis=%b cpu_rst=%b ready=%b, expected ovf=%b mis=%b cpu_rst=1 ready=0",
               name, err_overflow, err_misaligned, cpu_rst, s_ready, ovf, (!ovf && (n % 4) != 0));
    end
  endtask

  task automatic test_after_done();
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL after_done: got ready=%b we=%b done=%b, expected ready=0 we=0 done=1", s_ready, imem_we, done);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic fill_random(input int unsigned n);
    img.delete();
    for (int unsigned i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  task automatic test_normal();
    test_reset(); test_clear();
    img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    run_and_check("normal", 1'b0);
    test_after_done();
  endtask

  task automatic test_misaligned();
    test_reset(); test_clear();
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_and_check("misaligned", 1'b0);
  endtask

  task automatic test_overflow();
    test_reset(); test_clear();
    fill_random(LAST * 4 + 8);
    run_and_check("overflow", 1'b0);
  endtask

  task automatic test_back_pressure();
    test_reset(); test_clear();
    fill_random(16);
    run_and_check("gaps", 1'b1);
  endtask

  task automatic test_reset_mid_load();
    test_reset(); test_clear();
    fill_random(12);
    drive(5, 1'b0);
    test_reset();
    test_clear();
    run_and_check("reload", 1'b0);
  endtask

  task automatic test_random_lengths();
    for (int r = 0; r < 5; r++) begin
      test_reset(); test_clear();
      fill_random((r == 0) ? 1 : (r == 1) ? LAST * 4 + 1 : $urandom_range(1, 130));
      run_and_check("random", 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    test_reset();
    test_clear();
    test_normal();
    test_misaligned();
    test_overflow();
    test_back_pressure();
    test_reset_mid_load();
    test_random_lengths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader sitting directly upstream of the `risc_v` core. It takes a byte stream with a valid/ready handshake and fills instruction memory through a dedicated write port. Before loading, it clears every word to NOOP; after loading, it writes a branch-to-self halt into the last word. It holds the core in reset until the whole image is in place, which replaces `$readmemb` preloading so the same image path works in simulation and on hardware.

## Interface
Parameters:
- `INSTR_ADDRESS_WIDTH`, 5: word address width of instruction memory; depth = 2^W words.
- `CPU_DATA_WIDTH`, 32: instruction word width. Must be 32.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-low. Asserted when `rst == RESET`, with `RESET` = 1'b0 from `common`.
- `s_valid`  in  1  stream byte valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `s_data`  in  8  stream byte, little-endian within each word.
- `s_last`  in  1  qualifies the final byte of the image.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  W  word address.
- `imem_wdata`  out  32  word to write.
- `cpu_rst`  out  1  reset to the core, same polarity as `rst`.
- `done`  out  1  image loaded and core released.
- `err_overflow`  out  1  sticky: image exceeded 2^W−1 words.
- `err_misaligned`  out  1  sticky: `s_last` arrived on a byte that was not byte 3 of a word.

## Operation
- FSM states and transitions:
  - CLEAR: writes NOOP (0x00000013) to address 0..2^W−1, one per cycle, then goes to RECEIVE.
  - RECEIVE: accepts bytes and packs them into words.
  - DRAIN: discards bytes after an overflow until `s_last`.
  - HALT: writes 0x00000063 to address 2^W−1, then goes to DONE.
  - DONE: terminal until reset.
- Byte accept: a byte is taken only when `s_valid && s_ready`. `s_ready` = 1 only in RECEIVE and DRAIN.
- Byte packing:
  - Byte k (0..3) of a word lands in bits [8k+7:8k].
  - Write address starts at 0 and increments by 1 per completed word.
- Word completion: the word completes on byte 3, or on `s_last`. It is then written on the next cycle.
- Partial word on `s_last`:
  - Missing upper bytes are written as zero.
  - `err_misaligned` is set.
  - The FSM goes to HALT after the write.
- Capacity:
  - The last address is reserved for the halt instruction, so the usable capacity is 2^W−1 words.
  - A byte accepted when the word address equals 2^W−1 sets `err_overflow` and the FSM enters DRAIN. Nothing is written.
  - DRAIN keeps `s_ready` = 1, discards bytes, and goes to HALT on `s_last`.
- Empty image: `s_last` can only arrive with a byte, so a one-byte image gives one partial word. A zero-byte image is impossible.
- Core reset: `cpu_rst` = RESET in every state except DONE. `done` = 1 only in DONE.
- Stream after completion: extra stream bytes in HALT or DONE are not accepted (`s_ready` = 0).

## Timing
- All outputs are registered.
- Reset values (cycle after `rst` is sampled low):
  - `s_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_rst` = RESET, `done` = 0, both error flags = 0.
  - State = CLEAR.
- CLEAR:
  - The first clear write (`imem_we` = 1, addr 0) appears 1 cycle after reset is released.
  - It lasts 2^W consecutive cycles.
  - `s_ready` rises the cycle after the last clear write.
- Word write latency: `imem_we` pulses for exactly 1 cycle, 1 cycle after the completing byte is accepted.
- Throughput: one byte per cycle. `s_ready` stays high during the write cycle, so there are no bubbles.
- Halt write: occurs 1 cycle after the final data write (or after `s_last` in DRAIN).
- Release: `cpu_rst` = ~RESET and `done` = 1 from the cycle after the halt write.
- Reset mid-operation (any state): the next edge restores all reset values. A partially packed word is discarded and the error flags are cleared.
- Simultaneous events: `s_last` together with byte 3 counts as a full word, so `err_misaligned` stays 0.

## Structure
- In `common`:
  - Add `NOOP` if absent.
  - Add `HALT_INSTR` = 32'h00000063.
  - Add `loader_state_t` enum {CLEAR, RECEIVE, DRAIN, HALT, DONE}.
  - Reuse `RESET`.
- Sub-module `byte_packer`: holds the byte index and the 32-bit shift/insert register. It has inputs push/byte/last/flush, and outputs word_valid/word/partial. Address and FSM logic stay in `instr_loader`.
- Top-level hookup: `risc_v` gets an instruction-memory write port muxed in front of the fetch read port. `instr_loader.cpu_rst` drives the core reset.

## Test plan
- **Clear:** reset, W=5, `s_valid` = 0 → 32 writes of 0x00000013 to addr 0..31, then `s_ready` = 1, `cpu_rst` = 0, `done` = 0.
- **Normal load:** stream bytes 13 05 A0 00 | 93 05 B0 00 with `s_last` on the 8th byte → writes 0x00A00513 @0 and 0x00B00593 @1, then 0x00000063 @31, then `done` = 1, `cpu_rst` = 1, no error flags.
- **Misaligned end:** 6 bytes 01..06, `s_last` on byte 6 → 0x04030201 @0, 0x00000605 @1, `err_misaligned` = 1, halt @31, `done` = 1.
- **Overflow:** 31 full words, then 8 more bytes with `s_last` on the last one → addr 0..30 written, extra bytes accepted but not written, `err_overflow` = 1, halt @31, `done` = 1.
- **Back-pressure gaps:** `s_valid` toggled randomly over a 4-word image → identical memory image to the gap-free run.
- **Reset mid-load:** `rst` low after 5 bytes → next cycle all outputs at reset values, CLEAR restarts at addr 0, and a reload produces the correct image.
